ctrl_sequencer: RTL and testbench

- Control state machine that directly feeds the datapath output-signal decoder; produces its 5-bit `state` and 23-bit `opcode` inputs.
- Fetches one instruction word via a valid/request handshake and latches it into an instruction register (IR).
- Steps through the execute states for that instruction's class, then retires it and fetches the next.
- Sits between instruction memory/PC and the output-signal decoder in the simple CPU.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/op_classify.sv | 28 ++
 rtl/ctrl_sequencer.sv | 127 ++++++++++++
 tb/tb_ctrl_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the control sequencer and the output-signal decoder.
// CTRL_SINGLE_STEP_EN adds the PAUSE state code.
package ctrl_pkg;

  localparam int OPW  = 23;
  localparam int STW  = 5;
  localparam int CNTW = 16;

  localparam int CLS_HI = 22;
  localparam int CLS_LO = 20;
  localparam int RX_HI  = 19;
  localparam int RX_LO  = 16;
  localparam int RY_HI  = 15;
  localparam int RY_LO  = 12;

  localparam logic [2:0] CLS_LOAD = 3'b000;
  localparam logic [2:0] CLS_MOV  = 3'b001;
  localparam logic [2:0] CLS_ADD  = 3'b010;
  localparam logic [2:0] CLS_SUB  = 3'b011;
  localparam logic [2:0] CLS_XOR  = 3'b100;
  localparam logic [2:0] CLS_HALT = 3'b111;

  typedef enum logic [STW-1:0] {
    ST_IDLE     = 5'b00000,
    ST_LOAD     = 5'b00001,
    ST_MOV      = 5'b00010,
    ST_ARITH_A  = 5'b00011,
    ST_ARITH_G  = 5'b00100,
    ST_ARITH_WB = 5'b00101,
    ST_FETCH    = 5'b00110,
`ifdef CTRL_SINGLE_STEP_EN
    ST_HALT     = 5'b00111,
    ST_PAUSE    = 5'b01000
`else
    ST_HALT     = 5'b00111
`endif
  } state_t;

endpackage

// File: rtl/op_classify.sv
// Maps an instruction class to its first execute state and flags
// illegal and HALT classes.
module op_classify
  import ctrl_pkg::*;
(
  input  logic [2:0]     cls,
  output logic [STW-1:0] first_state,
  output logic           is_illegal,
  output logic           is_halt
);

  always_comb begin
    first_state = ST_FETCH;
    is_illegal  = 1'b0;
    is_halt     = 1'b0;
    case (cls)
      CLS_LOAD:                  first_state = ST_LOAD;
      CLS_MOV:                   first_state = ST_MOV;
      CLS_ADD, CLS_SUB, CLS_XOR: first_state = ST_ARITH_A;
      CLS_HALT: begin
        first_state = ST_HALT;
        is_halt     = 1'b1;
      end
      default:                   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/execute control FSM feeding the output-signal decoder.
// Optional CTRL_SINGLE_STEP_EN adds a step input and a PAUSE state after each retirement.
//
// Fetch handshake: instr_req is high for every cycle spent in FETCH; the word on
// instr is accepted on the first cycle where instr_req and instr_valid are both high.
module ctrl_sequencer
  import ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [OPW-1:0]  instr,
  input  logic            instr_valid,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            instr_req,
  output logic [STW-1:0]  state,
  output logic [OPW-1:0]  opcode,
  output logic [2:0]      alu_op,
  output logic            done,
  output logic            illegal,
  output logic            halted,
  output logic [CNTW-1:0] instr_count
);

  state_t          state_q, state_d, retire_next;
  logic [OPW-1:0]  ir_q, ir_d;
  logic [2:0]      alu_q, alu_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;
  logic            armed_q, armed_d;
  logic [CNTW-1:0] count_q;
  logic [STW-1:0]  first_state;
  logic            cls_illegal, cls_halt;

  op_classify u_classify (
    .cls         (instr[CLS_HI:CLS_LO]),
    .first_state (first_state),
    .is_illegal  (cls_illegal),
    .is_halt     (cls_halt)
  );

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = 1'b0;
    armed_d   = armed_q;
`ifdef CTRL_SINGLE_STEP_EN
    retire_next = run ? ST_PAUSE : ST_IDLE;
`else
    retire_next = run ? ST_FETCH : ST_IDLE;
`endif
    case (state_q)
      ST_IDLE:    if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d = instr;
          if (cls_illegal) begin
            illegal_d = 1'b1;
            if (!run) state_d = ST_IDLE;
          end else begin
            state_d = state_t'(first_state);
            if (cls_halt) armed_d = 1'b0;
          end
        end else if (!run) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD, ST_MOV, ST_ARITH_WB: state_d = retire_next;
      ST_ARITH_A: state_d = ST_ARITH_G;
      ST_ARITH_G: state_d = ST_ARITH_WB;
      // Leaving HALT needs run low at some point, then high again.
      ST_HALT: begin
        if (!run) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
`ifdef CTRL_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (!run)      state_d = ST_IDLE;
        else if (step) state_d = ST_FETCH;
      end
`endif
      default:    state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_LOAD) || (state_d == ST_MOV) || (state_d == ST_ARITH_WB) ||
             ((state_d == ST_HALT) && (state_q != ST_HALT));
    alu_d  = ((state_d == ST_ARITH_A) || (state_d == ST_ARITH_G) || (state_d == ST_ARITH_WB))
             ? ir_d[CLS_HI:CLS_LO] : 3'b000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      alu_q     <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      armed_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      alu_q     <= alu_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      armed_q   <= armed_d;
      // Retirement is counted at the end of the done cycle.
      if (done_q) count_q <= count_q + 1'b1;
    end
  end

  assign instr_req   = (state_q == ST_FETCH);
  assign state       = state_q;
  assign opcode      = ir_q;
  assign alu_op      = alu_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign halted      = (state_q == ST_HALT);
  assign instr_count = count_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer (default build).
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [22:0] instr = '0;
  logic        instr_valid = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif
  logic        instr_req;
  logic [4:0]  state;
  logic [22:0] opcode;
  logic [2:0]  alu_op;
  logic        done, illegal, halted;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_fail   = 0;

  ctrl_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .instr       (instr),
    .instr_valid (instr_valid),
`ifdef CTRL_SINGLE_STEP_EN
    .step        (step),
`endif
    .instr_req   (instr_req),
    .state       (state),
    .opcode      (opcode),
    .alu_op      (alu_op),
    .done        (done),
    .illegal     (illegal),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if (state !== 5'b00000) begin n_fail++; $display("FAIL reset_state: got %b want 00000", state); end
    n_checks++; if ({instr_req, done, illegal, halted} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {instr_req, done, illegal, halted}); end
    n_checks++; if ({opcode, alu_op, instr_count} !== 42'd0) begin n_fail++; $display("FAIL reset_data: got op %h alu %b cnt %h want 0", opcode, alu_op, instr_count); end
    reset = 1'b0;
  endtask

  task automatic test_load();
    run = 1'b1;
    @(negedge clk);
    n_checks++; if (state !== 5'b00110 || instr_req !== 1'b1) begin n_fail++; $display("FAIL load_fetch: got st %b req %b want 00110 1", state, instr_req); end
    instr_valid = 1'b1; instr = 23'h0A0000;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (state !== 5'b00001 || done !== 1'b1) begin n_fail++; $display("FAIL load_exec: got st %b done %b want 00001 1", state, done); end
    n_checks++; if (opcode !== 23'h0A0000) begin n_fail++; $display("FAIL load_opcode: got %h want 0a0000", opcode); end
    @(negedge clk);
    n_checks++; if (state !== 5'b00110 || done !== 1'b0 || instr_count !== 16'd1) begin n_fail++; $display("FAIL load_retire: got st %b done %b cnt %0d want 00110 0 1", state, done, instr_count); end
  endtask

  task automatic test_add();
    logic [4:0] exp_st [3] = '{5'b00011, 5'b00100, 5'b00101};
    instr_valid = 1'b1; instr = 23'h223000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      n_checks++; if (state !== exp_st[i] || alu_op !== 3'b010 || done !== (i == 2)) begin
        n_fail++; $display("FAIL add_step%0d: got st %b alu %b done %b want %b 010 %0d", i, state, alu_op, done, exp_st[i], (i == 2));
      end
    end
    @(negedge clk);
    n_checks++; if (state !== 5'b00110 || done !== 1'b0 || alu_op !== 3'b000 || instr_count !== 16'd2) begin
      n_fail++; $display("FAIL add_retire: got st %b done %b alu %b cnt %0d want 00110 0 000 2", state, done, alu_op, instr_count);
    end
  endtask

  task automatic test_fetch_stall();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (state !== 5'b00110 || instr_req !== 1'b1 || instr_count !== 16'd2) begin
        n_fail++; $display("FAIL stall_c%0d: got st %b req %b cnt %0d want 00110 1 2", i, state, instr_req, instr_count);
      end
    end
  endtask

  task automatic test_illegal();
    instr_valid = 1'b1; instr = 23'h500000;
    @(negedge clk);
    n_checks++; if (state !== 5'b00110 || illegal !== 1'b1 || done !== 1'b0 || instr_count !== 16'd2) begin
      n_fail++; $display("FAIL illegal_pulse: got st %b ill %b done %b cnt %0d want 00110 1 0 2", state, illegal, done, instr_count);
    end
    instr = 23'h134000;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (state !== 5'b00010 || illegal !== 1'b0 || done !== 1'b1 || opcode !== 23'h134000) begin
      n_fail++; $display("FAIL illegal_mov: got st %b ill %b done %b op %h want 00010 0 1 134000", state, illegal, done, opcode);
    end
    @(negedge clk);
    n_checks++; if (state !== 5'b00110 || instr_count !== 16'd3) begin n_fail++; $display("FAIL illegal_count: got st %b cnt %0d want 00110 3", state, instr_count); end
  endtask

  task automatic test_run_drop();
    instr_valid = 1'b1; instr = 23'h334000;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== 5'b00100 || alu_op !== 3'b011) begin n_fail++; $display("FAIL drop_g: got st %b alu %b want 00100 011", state, alu_op); end
    run = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== 5'b00101 || done !== 1'b1) begin n_fail++; $display("FAIL drop_wb: got st %b done %b want 00101 1", state, done); end
    @(negedge clk);
    n_checks++; if (state !== 5'b00000 || instr_req !== 1'b0 || instr_count !== 16'd4) begin
      n_fail++; $display("FAIL drop_idle: got st %b req %b cnt %0d want 00000 0 4", state, instr_req, instr_count);
    end
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    @(negedge clk);
    instr_valid = 1'b1; instr = 23'h456000;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (state !== 5'b00011 || alu_op !== 3'b100) begin n_fail++; $display("FAIL mid_arith_a: got st %b alu %b want 00011 100", state, alu_op); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (state !== 5'b00000 || {instr_req, done, illegal, halted} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_reset_ctl: got st %b flags %b want 00000 0000", state, {instr_req, done, illegal, halted});
    end
    n_checks++; if ({opcode, alu_op, instr_count} !== 42'd0) begin n_fail++; $display("FAIL mid_reset_data: got op %h alu %b cnt %h want 0", opcode, alu_op, instr_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1; instr = 23'h0A0000;
    @(negedge clk);
    n_checks++; if (state !== 5'b00110) begin n_fail++; $display("FAIL b2b_fetch: got %b want 00110", state); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (state !== 5'b00001 || done !== 1'b1) begin n_fail++; $display("FAIL b2b_load%0d: got st %b done %b want 00001 1", i, state, done); end
      @(negedge clk);
      n_checks++; if (state !== 5'b00110 || instr_count !== 16'(i + 1)) begin n_fail++; $display("FAIL b2b_cnt%0d: got st %b cnt %0d want 00110 %0d", i, state, instr_count, i + 1); end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_wrap();
    run = 1'b0;
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    n_checks++; if (state !== 5'b00000 || instr_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preset: got st %b cnt %h want 00000 ffff", state, instr_count); end
    run = 1'b1;
    @(negedge clk);
    instr_valid = 1'b1; instr = 23'h134000;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== 5'b00110 || instr_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got st %b cnt %h want 00110 0000", state, instr_count); end
  endtask

  task automatic test_halt();
    instr_valid = 1'b1; instr = 23'h700000;
    @(negedge clk);
    instr_valid = 1'b0;
    n_checks++; if (state !== 5'b00111 || halted !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL halt_entry: got st %b halted %b done %b want 00111 1 1", state, halted, done); end
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_checks++; if (halted !== 1'b1 || done !== 1'b0 || instr_count !== 16'd1) begin n_fail++; $display("FAIL halt_hold: got halted %b done %b cnt %0d want 1 0 1", halted, done, instr_count); end
    run = 1'b0;
    @(negedge clk);
    n_checks++; if (state !== 5'b00111 || halted !== 1'b1) begin n_fail++; $display("FAIL halt_runlow: got st %b halted %b want 00111 1", state, halted); end
    run = 1'b1;
    @(negedge clk);
    n_checks++; if (state !== 5'b00110 || halted !== 1'b0 || instr_req !== 1'b1) begin n_fail++; $display("FAIL halt_exit: got st %b halted %b req %b want 00110 0 1", state, halted, instr_req); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_fetch_stall();
    test_illegal();
    test_run_drop();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
